// File: rtl/img2col_ram_pkg.sv
// Shared types and helpers for the IMG2COL tile buffers.
package img2col_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Bits needed to index n words, never less than 1.
    function automatic int ram_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks the whole array writing zeros after reset or on request.
module ram_clr_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 10,
    parameter int MEM_LENGTH = 1024
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_W-1:0]     clr_addr,
    output logic [DATA_WIDTH-1:0] clr_data
);
    import img2col_ram_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_LENGTH - 1);

    ram_state_e        state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clka) begin
        if (rsta) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                cnt_nx = cnt + ADDR_W'(1);
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = CLEAR;
                cnt_nx   = '0;
            end
        endcase
    end

    // The array is left untouched on reset edges themselves.
    always_comb begin
        busy     = (state == CLEAR);
        clr_we   = (state == CLEAR) && !rsta;
        clr_addr = cnt;
        clr_data = '0;
    end

endmodule

// File: rtl/ram_t0_dp.sv
// Simple-dual-port tile buffer with hardware clear, 1/2-cycle read latency and RDW policy.
module ram_t0_dp #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_SIZE    = 10,
    parameter int MEM_LENGTH   = 1024,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);
    import img2col_ram_pkg::*;

    localparam int                 AW  = ram_clog2(MEM_LENGTH);
    localparam logic [ADDR_SIZE:0] LEN = (ADDR_SIZE + 1)'(MEM_LENGTH);

    logic                  clr_we;
    logic [AW-1:0]         clr_addr;
    logic [DATA_WIDTH-1:0] clr_data;

    ram_clr_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (AW),
        .MEM_LENGTH (MEM_LENGTH)
    ) u_clr_seq (
        .clka     (clka),
        .rsta     (rsta),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];

    logic                  wr_ok, rd_ok, rd_inr, wr_hit, mem_we;
    logic [AW-1:0]         mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    always_comb begin
        wr_ok  = wr_en && !busy && !rsta && ({1'b0, wr_addr} < LEN);
        rd_ok  = rd_en && !busy && !rsta;
        rd_inr = ({1'b0, rd_addr} < LEN);
        wr_hit = wr_ok && (wr_addr == rd_addr);
        mem_we = clr_we || wr_ok;
        mem_wa = clr_we ? clr_addr : wr_addr[AW-1:0];
        mem_wd = clr_we ? clr_data : wr_data;
    end

    always_ff @(posedge clka) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    logic                  v1;
    logic [DATA_WIDTH-1:0] d1;

    // Nonblocking array update means the plain array read is read-first.
    always_ff @(posedge clka) begin
        if (rsta) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_ok;
            if (rd_ok) begin
                if (!rd_inr)
                    d1 <= '0;
                else if (RDW_MODE == RDW_WRITE_FIRST && wr_hit)
                    d1 <= wr_data;
                else
                    d1 <= mem[rd_addr[AW-1:0]];
            end
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;

            always_ff @(posedge clka) begin
                if (rsta) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end

            always_comb begin
                rd_valid = v2;
                rd_data  = d2;
            end
        end else begin : g_lat1
            always_comb begin
                rd_valid = v1;
                rd_data  = d1;
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_t0_dp.sv
// Randomised plus directed bench comparing two ram_t0_dp configurations against an array model.
module tb_ram_t0_dp;

    localparam int MEM = 16;

    logic       clka = 1'b0;
    logic       rsta, clr_req, wr_en, rd_en;
    logic [4:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    logic       busy_a, busy_b, rd_valid_a, rd_valid_b;
    logic [7:0] rd_data_a, rd_data_b;

    always #5 clka = ~clka;

    // A: latency 1, read-first.  B: latency 2, write-first.
    ram_t0_dp #(
        .DATA_WIDTH   (8),
        .ADDR_SIZE    (5),
        .MEM_LENGTH   (MEM),
        .READ_LATENCY (1),
        .RDW_MODE     (0)
    ) u_dut_a (
        .clka     (clka),
        .rsta     (rsta),
        .clr_req  (clr_req),
        .busy     (busy_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a)
    );

    ram_t0_dp #(
        .DATA_WIDTH   (8),
        .ADDR_SIZE    (5),
        .MEM_LENGTH   (MEM),
        .READ_LATENCY (2),
        .RDW_MODE     (1)
    ) u_dut_b (
        .clka     (clka),
        .rsta     (rsta),
        .clr_req  (clr_req),
        .busy     (busy_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: word array, remaining clear writes, and per-config output delay lines.
    logic [7:0] mm [MEM];
    int         clr_left = MEM;
    logic       av, bv, b1v;
    logic [7:0] ad, bd, b1d;

    task automatic model_edge();
        logic       bz, acc, wacc;
        logic [7:0] old, res_a, res_b;
        if (rsta) begin
            clr_left = MEM;
            av = 0; ad = '0; b1v = 0; b1d = '0; bv = 0; bd = '0;
        end else begin
            bz    = (clr_left != 0);
            acc   = rd_en && !bz;
            wacc  = wr_en && !bz && (wr_addr < 5'(MEM));
            old   = (rd_addr < 5'(MEM)) ? mm[rd_addr[3:0]] : 8'h00;
            res_a = old;
            res_b = (wacc && wr_addr == rd_addr) ? wr_data : old;
            bv = b1v;
            if (b1v) bd = b1d;
            b1v = acc;
            if (acc) b1d = res_b;
            av = acc;
            if (acc) ad = res_a;
            if (bz) begin
                mm[MEM - clr_left] = 8'h00;
                clr_left--;
            end else begin
                if (wacc) mm[wr_addr[3:0]] = wr_data;
                if (clr_req) clr_left = MEM;
            end
        end
    endtask

    task automatic tick();
        @(posedge clka);
        model_edge();
        #1;
        check("busy_a",  32'(busy_a),     32'(clr_left != 0));
        check("busy_b",  32'(busy_b),     32'(clr_left != 0));
        check("valid_a", 32'(rd_valid_a), 32'(av));
        check("data_a",  32'(rd_data_a),  32'(ad));
        check("valid_b", 32'(rd_valid_b), 32'(bv));
        check("data_b",  32'(rd_data_b),  32'(bd));
    endtask

    task automatic drv(input logic rs, input logic cr, input logic we, input logic [4:0] wa,
                       input logic [7:0] wd, input logic re, input logic [4:0] ra);
        rsta = rs; clr_req = cr; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 5'd0, 8'h00, 0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) mm[i] = 8'h00;
        rsta = 1; clr_req = 0; wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 5'd0, 8'h00, 1, 5'd1);

        // Activity during the power-on clear must be ignored.
        for (int i = 0; i < 18; i++)
            drv(0, 0, 1, 5'($urandom_range(0, 15)), 8'($urandom), 1, 5'($urandom_range(0, 15)));

        for (int i = 0; i < MEM; i++) drv(0, 0, 0, 5'd0, 8'h00, 1, 5'(i));
        idle(3);

        drv(0, 0, 1, 5'd3, 8'hA5, 0, 5'd0);
        drv(0, 0, 0, 5'd0, 8'h00, 1, 5'd3);
        idle(3);

        drv(0, 0, 1, 5'd7, 8'h11, 0, 5'd0);
        drv(0, 0, 1, 5'd7, 8'h22, 1, 5'd7);
        drv(0, 0, 0, 5'd0, 8'h00, 1, 5'd7);
        idle(3);

        drv(0, 0, 1, 5'd4, 8'h44, 0, 5'd0);
        drv(0, 0, 1, 5'd20, 8'hFF, 0, 5'd0);
        drv(0, 0, 0, 5'd0, 8'h00, 1, 5'd20);
        drv(0, 0, 0, 5'd0, 8'h00, 1, 5'd4);
        idle(3);

        for (int i = 0; i < MEM; i++) drv(0, 0, 1, 5'(i), 8'h5A, 0, 5'd0);
        drv(0, 0, 0, 5'd0, 8'h00, 1, 5'd9);
        drv(0, 1, 0, 5'd0, 8'h00, 1, 5'd10);
        for (int i = 0; i < 5; i++) drv(0, 0, 1, 5'd2, 8'h77, 1, 5'd2);
        drv(0, 1, 0, 5'd0, 8'h00, 0, 5'd0);
        idle(12);
        for (int i = 0; i < MEM; i++) drv(0, 0, 0, 5'd0, 8'h00, 1, 5'(i));
        idle(3);

        for (int i = 0; i < MEM; i++) drv(0, 0, 1, 5'(i), 8'(i * 3 + 1), 0, 5'd0);
        drv(0, 1, 0, 5'd0, 8'h00, 0, 5'd0);
        idle(9);
        drv(1, 0, 0, 5'd0, 8'h00, 0, 5'd0);
        idle(MEM + 2);
        for (int i = 0; i < MEM; i++) drv(0, 0, 0, 5'd0, 8'h00, 1, 5'(i));

        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 19));
            drv(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
                1'($urandom), ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 19)),
                8'($urandom), 1'($urandom), a);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
